// File: rtl/gfx_rom_arbiter_if.sv
// Bundle of signals between the fetch requesters, the arbiter and the ROM bridge.
// The arbiter takes the slave view. The fetch logic and ROM model take the master view.
interface gfx_rom_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 16
);
    logic          spr_pri;
    logic          char_req;
    logic [AW-1:0] char_addr;
    logic          char_ack;
    logic          char_valid;
    logic [DW-1:0] char_data;
    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          spr_ack;
    logic          spr_valid;
    logic [DW-1:0] spr_data;
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [DW-1:0] rom_data;
    logic          busy;

    modport slave (
        input  spr_pri, char_req, char_addr, spr_req, spr_addr, rom_data,
        output char_ack, char_valid, char_data, spr_ack, spr_valid, spr_data,
               rom_addr, rom_rd, busy
    );

    modport master (
        output spr_pri, char_req, char_addr, spr_req, spr_addr, rom_data,
        input  char_ack, char_valid, char_data, spr_ack, spr_valid, spr_data,
               rom_addr, rom_rd, busy
    );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// Two-requester arbiter for the graphics ROM read port. Lane 0 is the char fetcher and lane 1 is the sprite renderer.
// It keeps one read in flight, completes it after a fixed latency and routes the result to the lane that won the grant.
module gfx_rom_arbiter_lane #(
    parameter int DW = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          grant,
    input  logic          done,
    input  logic [DW-1:0] rdata,
    output logic          ack,
    output logic          valid,
    output logic [DW-1:0] data
);
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack   <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            ack   <= grant;
            valid <= done;
            if (done) data <= rdata;
        end
    end
endmodule

module gfx_rom_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 16,
    parameter int LAT     = 2,
    parameter int MAXWAIT = 3
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    gfx_rom_arbiter_if.slave  bus
);
    localparam int NUM_LANES = 2;
    localparam int CHR       = 0;
    localparam int SPR       = 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [3:0] CNT_INIT   = 4'(LAT - 1);
    localparam logic [3:0] STREAK_LIM = 4'(MAXWAIT);

    logic [0:0]                     state;
    logic [3:0]                     cnt;
    logic [3:0]                     streak;
    logic                           win;
    logic                           pick;
    logic                           start;
    logic                           finish;
    logic [NUM_LANES-1:0]           req;
    logic [NUM_LANES-1:0]           grant;
    logic [NUM_LANES-1:0]           done;
    logic [NUM_LANES-1:0]           ack;
    logic [NUM_LANES-1:0]           valid;
    logic [NUM_LANES-1:0][AW-1:0]   addr;
    logic [NUM_LANES-1:0][DW-1:0]   data;

    assign req  = {bus.spr_req, bus.char_req};
    assign addr = {bus.spr_addr, bus.char_addr};

    // The sprite wins when it is alone, when the sprite window is open, or when it has waited MAXWAIT grants.
    always_comb begin
        pick   = req[SPR] && (!req[CHR] || bus.spr_pri || (streak >= STREAK_LIM));
        start  = (state == S_IDLE) && (|req);
        finish = (state == S_WAIT) && (cnt == 4'd0);
        grant  = '0;
        done   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            grant[i] = start  && (pick == 1'(i));
            done[i]  = finish && (win  == 1'(i));
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            streak       <= 4'd0;
            win          <= 1'b0;
            bus.rom_addr <= '0;
            bus.rom_rd   <= 1'b0;
        end else begin
            bus.rom_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bus.rom_addr <= addr[pick];
                        bus.rom_rd   <= 1'b1;
                        win          <= pick;
                        cnt          <= CNT_INIT;
                        state        <= S_WAIT;
                        // Only a char grant that beats a waiting sprite counts toward starvation.
                        if (!pick && req[SPR])
                            streak <= (streak == 4'hF) ? streak : streak + 4'd1;
                        else
                            streak <= 4'd0;
                    end
                end
                default: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        gfx_rom_arbiter_lane #(.DW(DW)) u_lane (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .grant   (grant[g]),
            .done    (done[g]),
            .rdata   (bus.rom_data),
            .ack     (ack[g]),
            .valid   (valid[g]),
            .data    (data[g])
        );
    end

    assign bus.char_ack   = ack[CHR];
    assign bus.char_valid = valid[CHR];
    assign bus.char_data  = data[CHR];
    assign bus.spr_ack    = ack[SPR];
    assign bus.spr_valid  = valid[SPR];
    assign bus.spr_data   = data[SPR];
    assign bus.busy       = (state == S_WAIT);
endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Bench for gfx_rom_arbiter. It applies a directed vector table and hand sequences for arbitration, reset and LAT=1.
// It then drives random requests and checks them against a timeline model of grants and completions.
module tb_gfx_rom_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int LAT = 2;
    localparam int MAXWAIT = 3;

    typedef struct {
        logic          cack, sack, rd;
        logic [AW-1:0] raddr;
        logic          cv, sv;
        logic [DW-1:0] cdata, sdata;
        logic          busy;
    } out_t;

    typedef struct {
        logic          creq;
        logic [AW-1:0] caddr;
        logic          sreq;
        logic [AW-1:0] saddr;
        logic          pri;
        out_t          exp;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk_sys = ~clk_sys;

    gfx_rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    gfx_rom_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    gfx_rom_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAXWAIT(MAXWAIT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
    gfx_rom_arbiter #(.AW(AW), .DW(DW), .LAT(1), .MAXWAIT(MAXWAIT)) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus1));

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return 16'h1291 ^ {3'b000, a};
    endfunction

    // ROM models: data is valid only on the edge LAT cycles after the read strobe rises, and 0xFFFF otherwise.
    logic [DW-1:0] rom_q;
    always @(posedge clk_sys) rom_q <= bus.rom_rd ? rom_f(bus.rom_addr) : 16'hFFFF;
    assign bus.rom_data  = rom_q;
    assign bus1.rom_data = bus1.rom_rd ? rom_f(bus1.rom_addr) : 16'hFFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, ".char_ack"},   32'(bus.char_ack),   32'(e.cack));
        chk({tag, ".spr_ack"},    32'(bus.spr_ack),    32'(e.sack));
        chk({tag, ".rom_rd"},     32'(bus.rom_rd),     32'(e.rd));
        chk({tag, ".rom_addr"},   32'(bus.rom_addr),   32'(e.raddr));
        chk({tag, ".char_valid"}, 32'(bus.char_valid), 32'(e.cv));
        chk({tag, ".spr_valid"},  32'(bus.spr_valid),  32'(e.sv));
        chk({tag, ".char_data"},  32'(bus.char_data),  32'(e.cdata));
        chk({tag, ".spr_data"},   32'(bus.spr_data),   32'(e.sdata));
        chk({tag, ".busy"},       32'(bus.busy),       32'(e.busy));
    endtask

    task automatic drive(input logic creq, input logic [AW-1:0] caddr,
                         input logic sreq, input logic [AW-1:0] saddr, input logic pri);
        bus.char_req  = creq;
        bus.char_addr = caddr;
        bus.spr_req   = sreq;
        bus.spr_addr  = saddr;
        bus.spr_pri   = pri;
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(bus.busy), 32'd0);
    endtask

    vec_t          vec[8];
    out_t          zero_o;
    out_t          e;
    logic [7:0]    exp2;
    int            ng, last;
    logic          cr, sr, pri, spr_wins;
    logic [AW-1:0] ca, sa, a1, prev1;
    int            t, free_at, pend_at, streak_m;
    logic          pend, pend_spr;
    logic [DW-1:0] pend_d;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        zero_o = '{1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0};
        vec[0] = '{1'b1, 13'h0A5, 1'b0, 13'h0, 1'b0,
                   '{1'b1, 1'b0, 1'b1, 13'h0A5, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1}};
        vec[1] = '{1'b0, 13'h0A5, 1'b0, 13'h0, 1'b0,
                   '{1'b0, 1'b0, 1'b0, 13'h0A5, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1}};
        vec[2] = '{1'b0, 13'h0A5, 1'b0, 13'h0, 1'b0,
                   '{1'b0, 1'b0, 1'b0, 13'h0A5, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0}};
        vec[3] = '{1'b0, 13'h0A5, 1'b0, 13'h0, 1'b0,
                   '{1'b0, 1'b0, 1'b0, 13'h0A5, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0}};
        vec[4] = '{1'b0, 13'h0, 1'b1, 13'h1F00, 1'b0,
                   '{1'b0, 1'b1, 1'b1, 13'h1F00, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1}};
        vec[5] = '{1'b0, 13'h0, 1'b1, 13'h1F00, 1'b0,   // held in WAIT: ignored
                   '{1'b0, 1'b0, 1'b0, 13'h1F00, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1}};
        vec[6] = '{1'b0, 13'h0, 1'b0, 13'h1F00, 1'b0,
                   '{1'b0, 1'b0, 1'b0, 13'h1F00, 1'b0, 1'b1, 16'h1234, 16'h0D91, 1'b0}};
        vec[7] = '{1'b0, 13'h0, 1'b0, 13'h1F00, 1'b0,
                   '{1'b0, 1'b0, 1'b0, 13'h1F00, 1'b0, 1'b0, 16'h1234, 16'h0D91, 1'b0}};

        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
        bus1.char_req = 1'b0; bus1.char_addr = '0;
        bus1.spr_req  = 1'b0; bus1.spr_addr  = '0; bus1.spr_pri = 1'b0;

        // Reset state, then the single char read and single sprite read from the table
        repeat (3) step();
        cmp_out("reset", zero_o);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vec[i].creq, vec[i].caddr, vec[i].sreq, vec[i].saddr, vec[i].pri);
            step();
            cmp_out($sformatf("vec%0d", i), vec[i].exp);
        end

        // Both requesters held with char-first priority, so the sprite is forced after MAXWAIT char grants
        exp2 = 8'b1000_1000;
        ng = 0; last = 0;
        drive(1'b1, 13'h100, 1'b1, 13'h200, 1'b0);
        for (int c = 0; c < 40 && ng < 8; c++) begin
            step();
            if (bus.char_ack || bus.spr_ack) begin
                chk("s2_who", 32'(bus.spr_ack), 32'(exp2[ng]));
                chk("s2_both_ack", 32'(bus.char_ack & bus.spr_ack), 32'd0);
                if (ng > 0) chk("s2_gap", c - last, 32'd3);
                last = c; ng++;
            end
        end
        chk("s2_grants", ng, 32'd8);
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
        wait_idle("s2_idle");

        // The sprite window gives every grant to the sprite
        ng = 0;
        drive(1'b1, 13'h300, 1'b1, 13'h400, 1'b1);
        for (int c = 0; c < 40 && ng < 4; c++) begin
            step();
            chk("s3_no_char", 32'(bus.char_ack), 32'd0);
            if (bus.spr_ack) ng++;
        end
        chk("s3_grants", ng, 32'd4);
        // The sprite drops its request in the ack cycle, so the held char request wins next
        drive(1'b1, 13'h300, 1'b0, 13'h400, 1'b1);
        ng = 0;
        for (int c = 0; c < 10 && ng == 0; c++) begin
            step();
            chk("s4_no_spr_ack", 32'(bus.spr_ack), 32'd0);
            chk("s4_spr_valid", 32'(bus.spr_valid), 32'(c == 1));
            if (bus.char_ack) begin
                chk("s4_gap", c, 32'd2);
                ng = 1;
            end
        end
        chk("s4_char_grant", ng, 32'd1);
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("s4_spr_valid_hold", 32'(bus.spr_valid), 32'd0);
            chk("s4_spr_data_hold", 32'(bus.spr_data), 32'h1691);
        end
        wait_idle("s4_idle");

        // Reset arrives one edge before completion: no valid pulse, and the outputs clear at once
        drive(1'b1, 13'h055, 1'b0, 13'h0, 1'b0);
        step();
        chk("s5_ack", 32'(bus.char_ack), 32'd1);
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
        step();
        reset_n = 1'b0;
        #1;
        cmp_out("s5_async", zero_o);
        step();
        chk("s5_no_valid0", 32'(bus.char_valid), 32'd0);
        step();
        chk("s5_no_valid1", 32'(bus.char_valid), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vec[i].creq, vec[i].caddr, vec[i].sreq, vec[i].saddr, vec[i].pri);
            step();
            cmp_out($sformatf("s5_vec%0d", i), vec[i].exp);
        end

        // Random requests checked against a timeline model of grants and completions
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        e = zero_o;
        cr = 1'b0; sr = 1'b0; pri = 1'b0; ca = '0; sa = '0;
        t = 0; free_at = 0; pend = 1'b0; pend_spr = 1'b0; pend_at = 0; pend_d = '0; streak_m = 0;
        for (int k = 0; k < 1500; k++) begin
            drive(cr, ca, sr, sa, pri);
            step();
            e.cack = 1'b0; e.sack = 1'b0; e.rd = 1'b0; e.cv = 1'b0; e.sv = 1'b0;
            if (pend && t == pend_at) begin
                if (pend_spr) begin e.sv = 1'b1; e.sdata = pend_d; end
                else          begin e.cv = 1'b1; e.cdata = pend_d; end
                pend = 1'b0;
            end
            if (t >= free_at && (cr || sr)) begin
                spr_wins = sr && (!cr || pri || streak_m >= MAXWAIT);
                if (spr_wins) begin
                    e.sack = 1'b1; e.raddr = sa; streak_m = 0;
                end else begin
                    e.cack = 1'b1; e.raddr = ca;
                    streak_m = sr ? ((streak_m < 15) ? streak_m + 1 : 15) : 0;
                end
                e.rd = 1'b1;
                pend = 1'b1; pend_spr = spr_wins; pend_at = t + LAT;
                pend_d = rom_f(e.raddr); free_at = t + LAT + 1;
            end
            e.busy = pend;
            cmp_out("rnd", e);
            t++;
            if (cr) begin
                if (e.cack && $urandom_range(1, 0) == 1) cr = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                cr = 1'b1; ca = 13'($urandom);
            end
            if (sr) begin
                if (e.sack && $urandom_range(1, 0) == 1) sr = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                sr = 1'b1; sa = 13'($urandom);
            end
            if ($urandom_range(15, 0) == 0) pri = ~pri;
        end
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0);
        wait_idle("rnd_idle");

        // LAT=1 build with char_req held: one grant every 2 cycles, and the next address is presented at each ack
        a1 = 13'h123; prev1 = '0;
        bus1.char_addr = a1;
        bus1.char_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("s6_ack", 32'(bus1.char_ack), 32'(k % 2 == 0));
            chk("s6_rd", 32'(bus1.rom_rd), 32'(k % 2 == 0));
            chk("s6_valid", 32'(bus1.char_valid), 32'(k % 2 == 1));
            chk("s6_busy", 32'(bus1.busy), 32'(k % 2 == 0));
            if (k % 2 == 1) chk("s6_data", 32'(bus1.char_data), 32'(rom_f(prev1)));
            if (k % 2 == 0) begin
                prev1 = a1;
                a1 = a1 + 13'd7;
                bus1.char_addr = a1;
            end
        end
        bus1.char_req = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/gfx_rom_arbiter.md
Name: gfx_rom_arbiter

Overview:
- Shares the single graphics ROM read port between two fetch requesters: the char tile fetcher and the sprite line renderer.
- Sits between the video block's fetch logic and the ROM/SDRAM bridge.
- One read outstanding at a time. Read latency is fixed and set by a parameter.
- Priority is programmable: char-first with sprite anti-starvation, or sprite-first during the sprite fetch window.

Parameters:
AW, 13, ROM address width
DW, 16, ROM data width (plane1 in [15:8], plane2 in [7:0])
LAT, 2, ROM read latency in clk_sys cycles, legal range 1..15
MAXWAIT, 3, consecutive contested char grants allowed before sprite is forced, legal range 1..15

Ports:
clk_sys  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
spr_pri  in  1  1 = sprite has fixed priority (sprite fetch window)
char_req  in  1  char read request, level, held until char_ack seen
char_addr  in  AW  char ROM address, stable while char_req high
char_ack  out  1  one-cycle grant pulse to char requester
char_valid  out  1  one-cycle pulse: char_data updated
char_data  out  DW  last char read result, held between pulses
spr_req  in  1  sprite read request, level
spr_addr  in  AW  sprite ROM address
spr_ack  out  1  one-cycle grant pulse to sprite requester
spr_valid  out  1  one-cycle pulse: spr_data updated
spr_data  out  DW  last sprite read result, held between pulses
rom_addr  out  AW  ROM address, registered
rom_rd  out  1  one-cycle ROM read strobe, registered
rom_data  in  DW  ROM read data, valid LAT edges after rom_rd rises
busy  out  1  1 while a read is in flight (state WAIT)

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0, including both *_data and rom_addr; cnt 0, streak 0. An in-flight read is discarded, and no valid pulse follows it after release.
- States: IDLE and WAIT. The counter cnt is 4 bits.
- IDLE, at a clock edge with char_req or spr_req high:
  - select a winner;
  - rom_addr <= winner addr; rom_rd <= 1; winner ack <= 1;
  - cnt <= LAT-1; state -> WAIT.
- IDLE with no request: all strobes 0; stay.
- WAIT, every edge:
  - rom_rd <= 0; ack <= 0.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: winner data <= rom_data; winner valid <= 1; state -> IDLE.
  - Requests are ignored in WAIT, so no second grant can occur while req is still high the cycle after ack.
- valid and ack are always single-cycle. Both *_valid are deasserted in every cycle except the completion pulse.
- Timing: the grant edge is E. ack/rom_rd are high in cycle E..E+1. rom_data is sampled at edge E+LAT. valid is high in cycle E+LAT..E+LAT+1. The next grant can occur at edge E+LAT+1, giving a peak rate of one read per LAT+1 cycles.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high, spr_pri=1: sprite wins.
  - Both high, spr_pri=0: sprite wins if streak >= MAXWAIT, otherwise char wins.
- Streak update, evaluated only at IDLE grant edges:
  - Char granted while spr_req was high: streak+1, saturating at 15.
  - Sprite granted: streak 0.
  - Char granted with spr_req low: streak 0.
- The winner identity is registered at grant and used to route the completion. Mid-flight changes to spr_pri or req do not affect routing.
- Requester rule: drop req in the cycle ack is seen, or keep it high to request the next read. A held req is re-arbitrated at the next IDLE edge.
- busy = (state == WAIT).

Test Plan:
1. Reset, then char_req=1 with char_addr=0x0A5 at edge 0; model ROM returns 0x1234 at edge 2 (LAT=2) -> rom_rd and char_ack high in cycle 0..1 with rom_addr=0x0A5; char_valid high in cycle 2..3 with char_data=0x1234; spr_* outputs stay 0.
2. Both req held high continuously, spr_pri=0, MAXWAIT=3 -> grant order char, char, char, spr, char, char, char, spr; grants 3 cycles apart.
3. Both req high with spr_pri=1 -> every grant goes to sprite; streak stays 0; char never granted until spr_req drops.
4. spr_req drops the cycle after spr_ack while char_req is held -> next IDLE edge grants char; spr_data keeps its last value and spr_valid stays 0.
5. reset_n pulsed low mid-WAIT, one edge before completion -> no valid pulse; outputs immediately 0; after release the first grant behaves as in scenario 1.
6. LAT=1 build, char_req held -> ack every 2 cycles; data sampled 1 edge after rom_rd rises.
